// File: rtl/mux2_rr_arbiter_pkg.sv
// rtl/mux2_rr_arbiter_pkg.sv - shared state encoding and width helper for the 2:1 round-robin arbiter
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// rtl/mux2_rr_arbiter_mux.sv - combinational 2:1 mux carrying beat data plus last flag
module mux2_data #(
  parameter int W = 9
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - packet-aware round-robin arbiter sharing one valid/ready channel between two requesters
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int CNT_W = clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nxt;
  logic             sel_nxt;
  logic             last_gnt, last_gnt_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             xfer;
  logic             other_valid;
  logic             release_now;

  mux2_data #(.W(DATA_W + 1)) u_mux (
    .sel (sel),
    .a   ({req0_last, req0_data}),
    .b   ({req1_last, req1_data}),
    .y   ({out_last, out_data})
  );

  // last_gnt resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= 1'b0;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      last_gnt <= last_gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    last_gnt_nxt = last_gnt;
    beat_cnt_nxt = beat_cnt;
    other_valid  = (state == ST_GNT1) ? req0_valid : req1_valid;
    release_now  = out_last || ((beat_cnt == CNT_TOP) && other_valid);
    case (state)
      ST_IDLE: begin
        if (req0_valid && req1_valid) begin
          state_nxt = last_gnt ? ST_GNT0 : ST_GNT1;
          sel_nxt   = ~last_gnt;
        end else if (req0_valid) begin
          state_nxt = ST_GNT0;
          sel_nxt   = 1'b0;
        end else if (req1_valid) begin
          state_nxt = ST_GNT1;
          sel_nxt   = 1'b1;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (xfer) begin
          if (release_now) begin
            last_gnt_nxt = (state == ST_GNT1);
            beat_cnt_nxt = '0;
            // hand straight over to a waiting peer; otherwise pass through IDLE to re-arbitrate
            if (other_valid) begin
              state_nxt = (state == ST_GNT0) ? ST_GNT1 : ST_GNT0;
              sel_nxt   = (state == ST_GNT0);
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            beat_cnt_nxt = (beat_cnt == CNT_TOP) ? '0 : beat_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid  = ((state == ST_GNT0) && req0_valid) || ((state == ST_GNT1) && req1_valid);
    req0_ready = (state == ST_GNT0) && out_ready;
    req1_ready = (state == ST_GNT1) && out_ready;
    busy       = (state != ST_IDLE);
    xfer       = out_valid && out_ready;
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter against a tenure-level reference model
module tb_mux2_rr_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_last, req0_ready;
  logic [DW-1:0] req0_data;
  logic          req1_valid, req1_last, req1_ready;
  logic [DW-1:0] req1_data;
  logic          out_valid, out_last, out_ready, sel, busy;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [DW:0] src0[$];
  logic [DW:0] src1[$];
  logic [DW:0] expq[$];
  bit          rdyq[$];
  bit          always_v;
  bit          rdy_rand;

  // reference model: who owns the channel, beats moved in this tenure, who was served last
  int owner;
  int sel_m;
  int lastw;
  int run;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    sel_m = 0;
    lastw = 1;
    run   = 0;
  endtask

  task automatic add_pkt(input int who, input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) begin
      if (who == 0) src0.push_back({i == len - 1, base + DW'(i)});
      else          src1.push_back({i == len - 1, base + DW'(i)});
    end
  endtask

  task automatic drive();
    req0_valid = (src0.size() > 0) && (always_v || $urandom_range(0, 3) != 0);
    req1_valid = (src1.size() > 0) && (always_v || $urandom_range(0, 3) != 0);
    if (src0.size() > 0) {req0_last, req0_data} = src0[0];
    else                 {req0_last, req0_data} = 9'($urandom);
    if (src1.size() > 0) {req1_last, req1_data} = src1[0];
    else                 {req1_last, req1_data} = 9'($urandom);
    if (rdyq.size() > 0) out_ready = rdyq.pop_front();
    else                 out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic step(input bit rst_mid);
    logic [1:0] vv, lv;
    bit         xm;
    int         oth;
    @(negedge clk);
    drive();
    #1;
    vv = {req1_valid, req0_valid};
    lv = {req1_last, req0_last};
    xm = (owner >= 0) && vv[owner[0]] && out_ready;
    chk("busy", busy, owner >= 0);
    chk("sel", sel, sel_m);
    chk("out_valid", out_valid, (owner >= 0) && vv[owner[0]]);
    chk("req0_ready", req0_ready, (owner == 0) && out_ready);
    chk("req1_ready", req1_ready, (owner == 1) && out_ready);
    if (xm) expq.push_back(owner == 0 ? src0[0] : src1[0]);
    if (rst_mid) begin
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sel", sel, 0);
      src0.delete();
      src1.delete();
      expq.delete();
      xm = 1'b0;
    end
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (owner < 0) begin
      if (vv == 2'b11)  owner = 1 - lastw;
      else if (vv[0])   owner = 0;
      else if (vv[1])   owner = 1;
      if (owner >= 0) begin
        sel_m = owner;
        run   = 0;
      end
    end else if (xm) begin
      if (owner == 0) void'(src0.pop_front());
      else            void'(src1.pop_front());
      run++;
      oth = 1 - owner;
      if (lv[owner[0]] || (run >= MB && vv[oth[0]])) begin
        lastw = owner;
        run   = 0;
        if (vv[oth[0]]) begin
          owner = oth;
          sel_m = oth;
        end else begin
          owner = -1;
        end
      end else if (run >= MB) begin
        run = 0;
      end
    end
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0) && n < budget) begin
      step(1'b0);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (3) step(1'b0);
    chk("scoreboard_drained", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        logic [DW:0] e;
        e = expq.pop_front();
        chk("out_data", out_data, e[DW-1:0]);
        chk("out_last", out_last, e[DW]);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    always_v   = 1'b1;
    rdy_rand   = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    req0_last  = 1'b0;
    req1_last  = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    repeat (10) step(1'b0);

    add_pkt(1, 3, 8'hA1);
    run_until_empty(20);

    add_pkt(0, 2, 8'h10);
    add_pkt(1, 2, 8'h20);
    run_until_empty(20);

    add_pkt(0, 10, 8'h30);
    add_pkt(1, 3, 8'h50);
    run_until_empty(40);

    add_pkt(0, 2, 8'h60);
    rdyq = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_until_empty(20);

    always_v = 1'b0;
    rdy_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (src0.size() < 3 && $urandom_range(0, 3) == 0) add_pkt(0, $urandom_range(1, 12), 8'($urandom));
      if (src1.size() < 3 && $urandom_range(0, 3) == 0) add_pkt(1, $urandom_range(1, 12), 8'($urandom));
      step(1'b0);
    end
    run_until_empty(400);

    always_v = 1'b1;
    rdy_rand = 1'b0;
    add_pkt(0, 4, 8'h70);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    rst_n = 1'b1;
    add_pkt(0, 2, 8'h80);
    add_pkt(1, 2, 8'h90);
    run_until_empty(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
